// File: rtl/alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : alu_reservation_station
// Purpose  : Integer ALU reservation station feeding the ROB submit path.
//            Holds renamed ALU instructions whose operands are either values
//            or pending ROB tags, resolves tags by snooping the CDB, and
//            dispatches the lowest-index ready entry each cycle through an
//            internal ALU. The result is presented on the submit_*_rs port.
// Ports    : clk_in/rst_in (async, active-low)/rdy_in (pause when low)
//            issue_*        - one instruction pushed per cycle when not full
//            cdb_*          - ROB broadcast used for tag resolution
//            predict_fail   - flush all entries
//            rs_full        - registered "all entries busy"
//            submit_*_rs    - dispatched tag/result and one-cycle valid pulse
// Revision : 1.0 - initial release
// ============================================================================
module alu_reservation_station #(
    parameter int RS_SIZE   = 8,
    parameter int RS_SIZE_W = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        issue_valid,
    input  logic [3:0]  issue_op,
    input  logic [3:0]  issue_tag,
    input  logic [31:0] issue_vj,
    input  logic [3:0]  issue_qj,
    input  logic        issue_qj_busy,
    input  logic [31:0] issue_vk,
    input  logic [3:0]  issue_qk,
    input  logic        issue_qk_busy,
    input  logic [3:0]  cdb_tag,
    input  logic [31:0] cdb_val,
    input  logic        cdb_active,
    input  logic        predict_fail,
    output logic        rs_full,
    output logic [3:0]  submit_tag_rs,
    output logic [31:0] submit_val_rs,
    output logic        submit_valid_rs
);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLL  = 4'd5;
    localparam logic [3:0] c_OP_SRL  = 4'd6;
    localparam logic [3:0] c_OP_SRA  = 4'd7;
    localparam logic [3:0] c_OP_SLT  = 4'd8;
    localparam logic [3:0] c_OP_SLTU = 4'd9;

    localparam logic [RS_SIZE_W:0] c_ONE        = {{RS_SIZE_W{1'b0}}, 1'b1};
    localparam logic [RS_SIZE_W:0] c_FULL_COUNT = (RS_SIZE_W+1)'(RS_SIZE);

    // Entry storage
    logic              r_busy    [RS_SIZE];
    logic [3:0]        r_op      [RS_SIZE];
    logic [3:0]        r_tag     [RS_SIZE];
    logic [31:0]       r_vj      [RS_SIZE];
    logic [3:0]        r_qj      [RS_SIZE];
    logic              r_qj_busy [RS_SIZE];
    logic [31:0]       r_vk      [RS_SIZE];
    logic [3:0]        r_qk      [RS_SIZE];
    logic              r_qk_busy [RS_SIZE];

    logic [RS_SIZE_W:0] r_count;
    logic               r_rs_full;
    logic [3:0]         r_submit_tag;
    logic [31:0]        r_submit_val;
    logic               r_submit_valid;

    logic                 w_free_found;
    logic [RS_SIZE_W-1:0] w_free_idx;
    logic                 w_rdy_found;
    logic [RS_SIZE_W-1:0] w_rdy_idx;
    logic                 w_accept;
    logic [RS_SIZE_W:0]   w_count_next;
    logic                 w_j_bypass;
    logic                 w_k_bypass;
    logic [31:0]          w_alu_result;

    function automatic logic [31:0] alu_calc(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] res;
        res = 32'd0;
        case (op)
            c_OP_ADD:  res = a + b;
            c_OP_SUB:  res = a - b;
            c_OP_AND:  res = a & b;
            c_OP_OR:   res = a | b;
            c_OP_XOR:  res = a ^ b;
            c_OP_SLL:  res = a << b[4:0];
            c_OP_SRL:  res = a >> b[4:0];
            c_OP_SRA:  res = $unsigned($signed(a) >>> b[4:0]);
            c_OP_SLT:  res = {31'd0, ($signed(a) < $signed(b))};
            c_OP_SLTU: res = {31'd0, (a < b)};
            default:   res = 32'd0;
        endcase
        return res;
    endfunction

    // Lowest-index free and ready entries; the loops run high-to-low so the
    // last hit (lowest index) wins. Both use registered state only, so an
    // entry freed this edge is not reused until the next.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_rdy_found  = 1'b0;
        w_rdy_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = RS_SIZE_W'(i);
            end
            if (r_busy[i] && !r_qj_busy[i] && !r_qk_busy[i]) begin
                w_rdy_found = 1'b1;
                w_rdy_idx   = RS_SIZE_W'(i);
            end
        end
    end

    assign w_accept     = issue_valid && !r_rs_full && w_free_found;
    assign w_j_bypass   = issue_qj_busy && cdb_active && (cdb_tag == issue_qj);
    assign w_k_bypass   = issue_qk_busy && cdb_active && (cdb_tag == issue_qk);
    assign w_alu_result = alu_calc(r_op[w_rdy_idx], r_vj[w_rdy_idx], r_vk[w_rdy_idx]);

    always_comb begin
        w_count_next = r_count;
        if (w_accept && !w_rdy_found) begin
            w_count_next = r_count + c_ONE;
        end else if (!w_accept && w_rdy_found) begin
            w_count_next = r_count - c_ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_busy[i]    <= 1'b0;
                r_op[i]      <= 4'd0;
                r_tag[i]     <= 4'd0;
                r_vj[i]      <= 32'd0;
                r_qj[i]      <= 4'd0;
                r_qj_busy[i] <= 1'b0;
                r_vk[i]      <= 32'd0;
                r_qk[i]      <= 4'd0;
                r_qk_busy[i] <= 1'b0;
            end
            r_count        <= '0;
            r_rs_full      <= 1'b0;
            r_submit_tag   <= 4'd0;
            r_submit_val   <= 32'd0;
            r_submit_valid <= 1'b0;
        end else if (!rdy_in) begin
            // Pause: everything holds except the one-cycle submit pulse.
            r_submit_valid <= 1'b0;
        end else if (predict_fail) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_busy[i] <= 1'b0;
            end
            r_count        <= '0;
            r_rs_full      <= 1'b0;
            r_submit_valid <= 1'b0;
        end else begin
            // Snoop: only pending operands of live entries may be captured.
            if (cdb_active) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i] && r_qj_busy[i] && (r_qj[i] == cdb_tag)) begin
                        r_vj[i]      <= cdb_val;
                        r_qj_busy[i] <= 1'b0;
                    end
                    if (r_busy[i] && r_qk_busy[i] && (r_qk[i] == cdb_tag)) begin
                        r_vk[i]      <= cdb_val;
                        r_qk_busy[i] <= 1'b0;
                    end
                end
            end

            // Dispatch; the freed entry never collides with the issue slot
            // because the issue slot was free in registered state.
            if (w_rdy_found) begin
                r_submit_tag      <= r_tag[w_rdy_idx];
                r_submit_val      <= w_alu_result;
                r_submit_valid    <= 1'b1;
                r_busy[w_rdy_idx] <= 1'b0;
            end else begin
                r_submit_valid <= 1'b0;
            end

            if (w_accept) begin
                r_busy[w_free_idx]    <= 1'b1;
                r_op[w_free_idx]      <= issue_op;
                r_tag[w_free_idx]     <= issue_tag;
                r_vj[w_free_idx]      <= w_j_bypass ? cdb_val : issue_vj;
                r_qj[w_free_idx]      <= issue_qj;
                r_qj_busy[w_free_idx] <= issue_qj_busy && !w_j_bypass;
                r_vk[w_free_idx]      <= w_k_bypass ? cdb_val : issue_vk;
                r_qk[w_free_idx]      <= issue_qk;
                r_qk_busy[w_free_idx] <= issue_qk_busy && !w_k_bypass;
            end

            r_count   <= w_count_next;
            r_rs_full <= (w_count_next == c_FULL_COUNT);
        end
    end

    assign rs_full         = r_rs_full;
    assign submit_tag_rs   = r_submit_tag;
    assign submit_val_rs   = r_submit_val;
    assign submit_valid_rs = r_submit_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_reservation_station
// Purpose  : Scoreboard bench for alu_reservation_station. Expected results
//            are queued when instructions are issued and popped whenever the
//            station pulses submit_valid_rs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_reservation_station;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] val;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic [3:0]  issue_op;
    logic [3:0]  issue_tag;
    logic [31:0] issue_vj;
    logic [3:0]  issue_qj;
    logic        issue_qj_busy;
    logic [31:0] issue_vk;
    logic [3:0]  issue_qk;
    logic        issue_qk_busy;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic        cdb_active;
    logic        predict_fail;
    logic        rs_full;
    logic [3:0]  submit_tag_rs;
    logic [31:0] submit_val_rs;
    logic        submit_valid_rs;

    int   r_errors  = 0;
    int   r_checks  = 0;
    int   r_submits = 0;
    exp_t r_sb[$];

    alu_reservation_station #(.RS_SIZE(8), .RS_SIZE_W(3)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .issue_valid    (issue_valid),
        .issue_op       (issue_op),
        .issue_tag      (issue_tag),
        .issue_vj       (issue_vj),
        .issue_qj       (issue_qj),
        .issue_qj_busy  (issue_qj_busy),
        .issue_vk       (issue_vk),
        .issue_qk       (issue_qk),
        .issue_qk_busy  (issue_qk_busy),
        .cdb_tag        (cdb_tag),
        .cdb_val        (cdb_val),
        .cdb_active     (cdb_active),
        .predict_fail   (predict_fail),
        .rs_full        (rs_full),
        .submit_tag_rs  (submit_tag_rs),
        .submit_val_rs  (submit_val_rs),
        .submit_valid_rs(submit_valid_rs)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] r;
        sh = b[4:0];
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a + (~b) + 32'd1;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << sh;
            4'd6:    r = a >> sh;
            4'd7:    r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd8:    r = ((a[31] ^ b[31]) ? a[31] : (a < b)) ? 32'd1 : 32'd0;
            4'd9:    r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Scoreboard side: every submit pulse must match the oldest expectation.
    always @(negedge clk_in) begin
        if (submit_valid_rs === 1'b1) begin
            exp_t e;
            r_submits++;
            check_eq("sb_nonempty", {31'd0, (r_sb.size() != 0)}, 32'd1);
            if (r_sb.size() != 0) begin
                e = r_sb.pop_front();
                check_eq("sub_tag", {28'd0, submit_tag_rs}, {28'd0, e.tag});
                check_eq("sub_val", submit_val_rs, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_in();
        issue_valid   = 1'b0;
        issue_op      = 4'd0;
        issue_tag     = 4'd0;
        issue_vj      = 32'd0;
        issue_qj      = 4'd0;
        issue_qj_busy = 1'b0;
        issue_vk      = 32'd0;
        issue_qk      = 4'd0;
        issue_qk_busy = 1'b0;
        cdb_active    = 1'b0;
        cdb_tag       = 4'd0;
        cdb_val       = 32'd0;
        predict_fail  = 1'b0;
    endtask

    task automatic set_issue(input logic [3:0] op, input logic [3:0] tag,
                             input logic [31:0] vj, input logic [3:0] qj, input logic qjb,
                             input logic [31:0] vk, input logic [3:0] qk, input logic qkb);
        issue_valid   = 1'b1;
        issue_op      = op;
        issue_tag     = tag;
        issue_vj      = vj;
        issue_qj      = qj;
        issue_qj_busy = qjb;
        issue_vk      = vk;
        issue_qk      = qk;
        issue_qk_busy = qkb;
    endtask

    task automatic push_exp(input logic [3:0] tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        r_sb.push_back(e);
    endtask

    initial begin
        logic [3:0]  ops [8];
        logic [31:0] big;
        int          base;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd12};
        big = 32'h8000_0013;

        rst_in = 1'b0;
        rdy_in = 1'b1;
        clear_in();
        tick(); tick();
        check_eq("rst_full",  {31'd0, rs_full}, 32'd0);
        check_eq("rst_valid", {31'd0, submit_valid_rs}, 32'd0);
        check_eq("rst_tag",   {28'd0, submit_tag_rs}, 32'd0);
        check_eq("rst_val",   submit_val_rs, 32'd0);
        rst_in = 1'b1;
        tick();

        // ADD with both operands ready: two edges of latency.
        set_issue(4'd0, 4'd3, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 1'b0);
        push_exp(4'd3, 32'd12);
        tick();
        clear_in();
        check_eq("add_early", {31'd0, submit_valid_rs}, 32'd0);
        tick();
        check_eq("add_valid", {31'd0, submit_valid_rs}, 32'd1);
        check_eq("add_full",  {31'd0, rs_full}, 32'd0);
        tick();
        check_eq("add_pulse", {31'd0, submit_valid_rs}, 32'd0);

        // SUB waiting on tag 9.
        set_issue(4'd1, 4'd2, 32'd0, 4'd9, 1'b1, 32'd1, 4'd0, 1'b0);
        push_exp(4'd2, 32'd9);
        tick();
        clear_in();
        base = r_submits;
        tick(); tick();
        check_eq("sub_wait", r_submits - base, 32'd0);
        cdb_active = 1'b1; cdb_tag = 4'd9; cdb_val = 32'd10;
        tick();
        clear_in();
        check_eq("sub_capture_edge", {31'd0, submit_valid_rs}, 32'd0);
        tick();
        check_eq("sub_valid", {31'd0, submit_valid_rs}, 32'd1);
        tick();

        // Issue-time bypass, SLTU then SLT against 0xFFFF_FFFF.
        set_issue(4'd9, 4'd5, 32'd1, 4'd0, 1'b0, 32'd0, 4'd4, 1'b1);
        cdb_active = 1'b1; cdb_tag = 4'd4; cdb_val = 32'hFFFF_FFFF;
        push_exp(4'd5, model_alu(4'd9, 32'd1, 32'hFFFF_FFFF));
        tick();
        clear_in();
        tick();
        check_eq("sltu_valid", {31'd0, submit_valid_rs}, 32'd1);
        set_issue(4'd8, 4'd6, 32'd1, 4'd0, 1'b0, 32'd0, 4'd4, 1'b1);
        cdb_active = 1'b1; cdb_tag = 4'd4; cdb_val = 32'hFFFF_FFFF;
        push_exp(4'd6, model_alu(4'd8, 32'd1, 32'hFFFF_FFFF));
        tick();
        clear_in();
        tick();
        check_eq("slt_valid", {31'd0, submit_valid_rs}, 32'd1);
        tick();

        // Fill all 8 entries pending on tag 15, then drop a 9th.
        for (int i = 0; i < 8; i++) begin
            set_issue(ops[i], 4'(i), 32'd0, 4'd15, 1'b1, 32'h0000_0104 + 32'(i), 4'd0, 1'b0);
            push_exp(4'(i), model_alu(ops[i], big, 32'h0000_0104 + 32'(i)));
            tick();
        end
        clear_in();
        check_eq("fill_full",  {31'd0, rs_full}, 32'd1);
        set_issue(4'd0, 4'd12, 32'd0, 4'd15, 1'b1, 32'd1, 4'd0, 1'b0);
        tick();
        clear_in();
        check_eq("drop_full",  {31'd0, rs_full}, 32'd1);
        check_eq("drop_count", 32'(dut.r_count), 32'd8);
        cdb_active = 1'b1; cdb_tag = 4'd15; cdb_val = big;
        tick();
        clear_in();
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("drain_valid", {31'd0, submit_valid_rs}, 32'd1);
            if (i == 0) check_eq("drain_full_clear", {31'd0, rs_full}, 32'd0);
        end
        tick();
        check_eq("drain_end",   {31'd0, submit_valid_rs}, 32'd0);
        check_eq("drain_count", 32'(dut.r_count), 32'd0);
        check_eq("drain_full",  {31'd0, rs_full}, 32'd0);

        // Flush with a concurrent issue: nothing may come out afterwards.
        for (int i = 0; i < 3; i++) begin
            set_issue(4'd0, 4'(10 + i), 32'd0, 4'd14, 1'b1, 32'd1, 4'd0, 1'b0);
            tick();
        end
        set_issue(4'd0, 4'd13, 32'd4, 4'd0, 1'b0, 32'd4, 4'd0, 1'b0);
        predict_fail = 1'b1;
        tick();
        clear_in();
        check_eq("flush_full",  {31'd0, rs_full}, 32'd0);
        check_eq("flush_count", 32'(dut.r_count), 32'd0);
        base = r_submits;
        cdb_active = 1'b1; cdb_tag = 4'd14; cdb_val = 32'd3;
        tick();
        clear_in();
        tick(); tick(); tick();
        check_eq("flush_quiet", r_submits - base, 32'd0);
        set_issue(4'd0, 4'd0, 32'd1, 4'd0, 1'b0, 32'd1, 4'd0, 1'b0);
        push_exp(4'd0, 32'd2);
        tick();
        clear_in();
        tick();
        check_eq("post_flush_valid", {31'd0, submit_valid_rs}, 32'd1);
        tick();

        // Pause: a pending XOR (entry 0) and a ready ADD (entry 1).
        set_issue(4'd4, 4'd8, 32'd0, 4'd13, 1'b1, 32'h0000_00F0, 4'd0, 1'b0);
        tick();
        set_issue(4'd0, 4'd7, 32'd100, 4'd0, 1'b0, 32'd23, 4'd0, 1'b0);
        tick();
        clear_in();
        rdy_in = 1'b0;
        push_exp(4'd7, 32'd123);
        push_exp(4'd8, 32'h0000_00FF);
        base = r_submits;
        for (int i = 0; i < 3; i++) begin
            cdb_active = 1'b1; cdb_tag = 4'd13; cdb_val = 32'h55;
            tick();
            check_eq("pause_valid", {31'd0, submit_valid_rs}, 32'd0);
        end
        clear_in();
        rdy_in = 1'b1;
        tick();
        check_eq("resume_valid", {31'd0, submit_valid_rs}, 32'd1);
        check_eq("pause_quiet",  r_submits - base, 32'd0);
        cdb_active = 1'b1; cdb_tag = 4'd13; cdb_val = 32'h0F;
        tick();
        clear_in();
        tick();
        check_eq("resume_xor_valid", {31'd0, submit_valid_rs}, 32'd1);
        tick();

        // Asynchronous reset while a submit pulse is high.
        set_issue(4'd0, 4'd1, 32'd2, 4'd0, 1'b0, 32'd3, 4'd0, 1'b0);
        tick();
        clear_in();
        tick();
        check_eq("pre_rst_valid", {31'd0, submit_valid_rs}, 32'd1);
        check_eq("pre_rst_val",   submit_val_rs, 32'd5);
        #2;
        rst_in = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'd0, submit_valid_rs}, 32'd0);
        check_eq("async_rst_val",   submit_val_rs, 32'd0);
        tick();
        rst_in = 1'b1;
        tick(); tick();
        check_eq("sb_drained", 32'(r_sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
